csr_access_sequencer: RTL and testbench

- Sits between the execute stage and CSR_Unit; executes Zicsr instructions (CSRRW/S/C and immediate forms).
- Reads the old CSR value and computes the new value per func3.
- Drives the CSR write handshake (write_enable/write_done), detects illegal accesses, and returns the old value for rd writeback.
- Stalls the pipeline while busy.

---
 rtl/csr_pkg.sv | 55 +++++
 rtl/csr_access_sequencer_if.sv | 45 ++++
 rtl/csr_alu.sv | 31 +++
 rtl/csr_access_sequencer.sv | 147 ++++++++++++++
 tb/tb_csr_access_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: func3 encodings, CSR address map, sequencer FSM states
// and the latched request control payload.
package csr_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned FUNC3_W    = 3;
    localparam int unsigned REG_IDX_W  = 5;

    localparam logic [FUNC3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [FUNC3_W-1:0] F3_CSRRS  = 3'b010;
    localparam logic [FUNC3_W-1:0] F3_CSRRC  = 3'b011;
    localparam logic [FUNC3_W-1:0] F3_CSRRWI = 3'b101;
    localparam logic [FUNC3_W-1:0] F3_CSRRSI = 3'b110;
    localparam logic [FUNC3_W-1:0] F3_CSRRCI = 3'b111;

    // Operation kind lives in func3[1:0]; func3[2] selects the immediate source.
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA     = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL    = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH   = 12'hC80;

    // Addresses 0xC00-0xFFF have addr[11:10]==2'b11: the read-only CSR space.
    localparam logic [CSR_ADDR_W-1:0] CSR_RO_BASE  = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WAIT_DONE,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic [FUNC3_W-1:0]    func3;
        logic [CSR_ADDR_W-1:0] csr_addr;
        logic [REG_IDX_W-1:0]  rs1_zimm;
        logic [REG_IDX_W-1:0]  rd;
    } req_ctl_t;

    function automatic logic csr_is_read_only(input logic [CSR_ADDR_W-1:0] addr);
        return addr >= CSR_RO_BASE;
    endfunction

endpackage

// File: rtl/csr_access_sequencer_if.sv
// Bundle of request, CSR_Unit and response signals around the CSR access sequencer.
interface csr_access_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_func3;
    logic [11:0]      req_csr_addr;
    logic [XLEN-1:0]  req_rs1_data;
    logic [4:0]       req_rs1_zimm;
    logic [4:0]       req_rd;

    logic [11:0]      csr_addr;
    logic [2:0]       csr_func3;
    logic [4:0]       csr_imm;
    logic [XLEN-1:0]  csr_rdata;
    logic [XLEN-1:0]  csr_wdata;
    logic             csr_we;
    logic             csr_write_done;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [4:0]       rsp_rd;
    logic             rsp_rd_we;
    logic [XLEN-1:0]  rsp_data;
    logic             rsp_illegal;
    logic             retire;
    logic             busy;

    // Sequencer side.
    modport slave (
        input  req_valid, req_func3, req_csr_addr, req_rs1_data, req_rs1_zimm, req_rd,
        input  csr_rdata, csr_write_done, rsp_ready,
        output req_ready, csr_addr, csr_func3, csr_imm, csr_wdata, csr_we,
        output rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_illegal, retire, busy
    );

    // Execute stage / CSR_Unit / writeback side.
    modport master (
        output req_valid, req_func3, req_csr_addr, req_rs1_data, req_rs1_zimm, req_rd,
        output csr_rdata, csr_write_done, rsp_ready,
        input  req_ready, csr_addr, csr_func3, csr_imm, csr_wdata, csr_we,
        input  rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_illegal, retire, busy
    );
endinterface

// File: rtl/csr_alu.sv
// Combinational Zicsr datapath: source select, new CSR value, write decision, legality.
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [FUNC3_W-1:0]    func3,
    input  logic [CSR_ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [REG_IDX_W-1:0]  rs1_zimm,
    input  logic [XLEN-1:0]       old_val,
    output logic [XLEN-1:0]       new_val_c,
    output logic                  do_write_c,
    output logic                  illegal_c
);
    logic [XLEN-1:0] src;

    always_comb begin
        src        = func3[2] ? XLEN'(rs1_zimm) : rs1_data;
        new_val_c  = old_val;
        unique case (func3[1:0])
            OP_RW:   new_val_c = src;
            OP_RS:   new_val_c = old_val | src;
            OP_RC:   new_val_c = old_val & ~src;
            default: new_val_c = old_val;
        endcase
        // Set/clear with x0 or zimm==0 is a pure read and may target read-only CSRs.
        do_write_c = (func3[1:0] == OP_RW) || (rs1_zimm != '0);
        illegal_c  = (func3[1:0] == 2'b00) || (do_write_c && csr_is_read_only(csr_addr));
    end
endmodule

// File: rtl/csr_access_sequencer.sv
// Executes one Zicsr instruction at a time: read old CSR value, optional write with
// done handshake and timeout, then return the old value for rd writeback.
module csr_access_sequencer
    import csr_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 8,
    parameter int unsigned XLEN         = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    csr_access_sequencer_if.slave bus
);
    localparam int unsigned TMO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

    seq_state_e       state_q, state_nxt;
    req_ctl_t         ctl_q, ctl_nxt;
    logic [XLEN-1:0]  rs1_q, rs1_nxt;
    logic [XLEN-1:0]  old_q, old_nxt;
    logic [XLEN-1:0]  wdata_q, wdata_nxt;
    logic             illegal_q, illegal_nxt;
    logic             rd_we_q, rd_we_nxt;
    logic [TMO_W-1:0] tmo_q, tmo_nxt;
    logic             req_ready_q, busy_q, rsp_valid_q, we_q;

    logic [XLEN-1:0]  alu_new_c;
    logic             alu_do_write_c;
    logic             alu_illegal_c;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .func3      (ctl_q.func3),
        .csr_addr   (ctl_q.csr_addr),
        .rs1_data   (rs1_q),
        .rs1_zimm   (ctl_q.rs1_zimm),
        .old_val    (bus.csr_rdata),
        .new_val_c  (alu_new_c),
        .do_write_c (alu_do_write_c),
        .illegal_c  (alu_illegal_c)
    );

    // State and datapath registers; handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctl_q       <= '0;
            rs1_q       <= '0;
            old_q       <= '0;
            wdata_q     <= '0;
            illegal_q   <= 1'b0;
            rd_we_q     <= 1'b0;
            tmo_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ctl_q       <= ctl_nxt;
            rs1_q       <= rs1_nxt;
            old_q       <= old_nxt;
            wdata_q     <= wdata_nxt;
            illegal_q   <= illegal_nxt;
            rd_we_q     <= rd_we_nxt;
            tmo_q       <= tmo_nxt;
            req_ready_q <= (state_nxt == ST_IDLE);
            busy_q      <= (state_nxt != ST_IDLE);
            rsp_valid_q <= (state_nxt == ST_RESP);
            we_q        <= (state_nxt == ST_WRITE);
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt   = state_q;
        ctl_nxt     = ctl_q;
        rs1_nxt     = rs1_q;
        old_nxt     = old_q;
        wdata_nxt   = wdata_q;
        illegal_nxt = illegal_q;
        rd_we_nxt   = rd_we_q;
        tmo_nxt     = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ctl_nxt.func3    = bus.req_func3;
                    ctl_nxt.csr_addr = bus.req_csr_addr;
                    ctl_nxt.rs1_zimm = bus.req_rs1_zimm;
                    ctl_nxt.rd       = bus.req_rd;
                    rs1_nxt          = bus.req_rs1_data;
                    illegal_nxt      = 1'b0;
                    rd_we_nxt        = 1'b0;
                    state_nxt        = ST_READ;
                end
            end
            ST_READ: begin
                old_nxt     = bus.csr_rdata;
                wdata_nxt   = alu_new_c;
                illegal_nxt = alu_illegal_c;
                rd_we_nxt   = !alu_illegal_c && (ctl_q.rd != '0);
                if (!alu_illegal_c && alu_do_write_c) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_WRITE: begin
                tmo_nxt   = '0;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done on the final allowed cycle still wins over the timeout.
                if (bus.csr_write_done) begin
                    state_nxt = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    illegal_nxt = 1'b1;
                    rd_we_nxt   = 1'b0;
                    state_nxt   = ST_RESP;
                end else begin
                    tmo_nxt = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.csr_addr    = ctl_q.csr_addr;
    assign bus.csr_func3   = ctl_q.func3;
    assign bus.csr_imm     = ctl_q.rs1_zimm;
    assign bus.csr_wdata   = wdata_q;
    assign bus.csr_we      = we_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd      = ctl_q.rd;
    assign bus.rsp_rd_we   = rd_we_q;
    assign bus.rsp_data    = old_q;
    assign bus.rsp_illegal = illegal_q;
    assign bus.busy        = busy_q;
    // Retire must coincide with the response handshake, so it is decoded, not registered.
    assign bus.retire      = rsp_valid_q && bus.rsp_ready && !illegal_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Directed bench for csr_access_sequencer with a small CSR_Unit model.
module tb_csr_access_sequencer;
    import csr_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_access_sequencer_if #(.XLEN(XLEN)) bus ();

    csr_access_sequencer #(.DONE_TIMEOUT(8), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // CSR_Unit model: combinational read, write_done done_delay cycles after write_enable.
    logic [31:0] csr_regs [0:4095];
    logic [31:0] cycle_q    = 32'd0;
    logic [3:0]  dcnt       = 4'd0;
    int          done_delay = 1;
    int          we_cnt     = 0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk) begin
        cycle_q <= cycle_q + 32'd1;
        if (!rst_n) begin
            csr_regs[CSR_MSTATUS]  <= 32'h0000_0088;
            csr_regs[CSR_MIE]      <= 32'h0000_000F;
            csr_regs[CSR_MTVEC]    <= 32'h0000_0100;
            csr_regs[CSR_MSCRATCH] <= 32'h0000_0000;
            csr_regs[CSR_MEPC]     <= 32'h0000_0000;
            dcnt                   <= 4'd0;
        end else if (bus.csr_we) begin
            csr_regs[bus.csr_addr] <= bus.csr_wdata;
            we_cnt                 <= we_cnt + 1;
            last_wdata             <= bus.csr_wdata;
            dcnt                   <= 4'(done_delay);
        end else if (dcnt != 4'd0) begin
            dcnt <= dcnt - 4'd1;
        end
    end

    assign bus.csr_rdata      = (bus.csr_addr == CSR_CYCLE) ? cycle_q : csr_regs[bus.csr_addr];
    assign bus.csr_write_done = (dcnt == 4'd1);

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int          r_lat;
    int          r_we;
    logic [31:0] r_data;
    logic [31:0] r_cyc_snap;
    logic        r_ill, r_rdwe, r_ret;
    logic [4:0]  r_rd;

    // Issue one instruction; hold > 0 keeps rsp_ready low for that many RESP cycles;
    // stop_at > 0 abandons the op at that cycle (cycle 1 = accept cycle).
    task automatic do_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic [4:0] rd, input int hold,
                         input int stop_at);
        int cyc;
        int we0;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_func3    = f3;
        bus.req_csr_addr = addr;
        bus.req_rs1_data = rs1;
        bus.req_rs1_zimm = zimm;
        bus.req_rd       = rd;
        bus.rsp_ready    = (hold == 0);
        we0 = we_cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) r_cyc_snap = cycle_q;
            if (cyc == stop_at) return;
            if (bus.rsp_valid) break;
        end
        r_lat = cyc;
        check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        r_data = bus.rsp_data;
        r_ill  = bus.rsp_illegal;
        r_rdwe = bus.rsp_rd_we;
        r_rd   = bus.rsp_rd;
        for (int h = 1; h < hold; h++) begin
            check("hold_busy", 32'(bus.busy), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_retire", 32'(bus.retire), 32'd0);
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data", bus.rsp_data, r_data);
            check("hold_rd", 32'(bus.rsp_rd), 32'(r_rd));
            check("hold_illegal", 32'(bus.rsp_illegal), 32'(r_ill));
        end
        bus.rsp_ready = 1'b1;
        #1;
        r_ret = bus.retire;
        @(posedge clk);
        #1;
        r_we = we_cnt - we0;
        check("retire_drop", 32'(bus.retire), 32'd0);
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.req_valid    = 1'b0;
        bus.req_func3    = 3'd0;
        bus.req_csr_addr = 12'd0;
        bus.req_rs1_data = 32'd0;
        bus.req_rs1_zimm = 5'd0;
        bus.req_rd       = 5'd0;
        bus.rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_csr_we", 32'(bus.csr_we), 32'd0);
        check("rst_retire", 32'(bus.retire), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_illegal", 32'(bus.rsp_illegal), 32'd0);
        rst_n = 1'b1;

        // CSRRW x5, mscratch, x6
        do_op(F3_CSRRW, CSR_MSCRATCH, 32'hDEAD_BEEF, 5'd6, 5'd5, 0, 0);
        check("rw_lat", 32'(r_lat), 32'd5);
        check("rw_we_pulses", 32'(r_we), 32'd1);
        check("rw_wdata", last_wdata, 32'hDEAD_BEEF);
        check("rw_csr_after", csr_regs[CSR_MSCRATCH], 32'hDEAD_BEEF);
        check("rw_data", r_data, 32'd0);
        check("rw_rd", 32'(r_rd), 32'd5);
        check("rw_rd_we", 32'(r_rdwe), 32'd1);
        check("rw_illegal", 32'(r_ill), 32'd0);
        check("rw_retire", 32'(r_ret), 32'd1);

        // CSRRS x7, mstatus, x0: pure read
        do_op(F3_CSRRS, CSR_MSTATUS, 32'd0, 5'd0, 5'd7, 0, 0);
        check("rs0_lat", 32'(r_lat), 32'd3);
        check("rs0_we_pulses", 32'(r_we), 32'd0);
        check("rs0_data", r_data, 32'h88);
        check("rs0_rd_we", 32'(r_rdwe), 32'd1);
        check("rs0_retire", 32'(r_ret), 32'd1);

        // CSRRCI x0, mie, 3: rs1_data must be ignored for the immediate form
        do_op(F3_CSRRCI, CSR_MIE, 32'hFFFF_FFFF, 5'd3, 5'd0, 0, 0);
        check("rci_lat", 32'(r_lat), 32'd5);
        check("rci_we_pulses", 32'(r_we), 32'd1);
        check("rci_wdata", last_wdata, 32'hC);
        check("rci_data", r_data, 32'hF);
        check("rci_rd_we", 32'(r_rdwe), 32'd0);
        check("rci_retire", 32'(r_ret), 32'd1);
        check("rci_func3", 32'(bus.csr_func3), 32'd7);
        check("rci_imm", 32'(bus.csr_imm), 32'd3);

        // CSRRW x2, cycle, x1: write to read-only space
        do_op(F3_CSRRW, CSR_CYCLE, 32'h55, 5'd1, 5'd2, 0, 0);
        check("ro_lat", 32'(r_lat), 32'd3);
        check("ro_we_pulses", 32'(r_we), 32'd0);
        check("ro_illegal", 32'(r_ill), 32'd1);
        check("ro_rd_we", 32'(r_rdwe), 32'd0);
        check("ro_retire", 32'(r_ret), 32'd0);

        // Reserved func3 100
        do_op(3'b100, CSR_MSTATUS, 32'h1, 5'd1, 5'd1, 0, 0);
        check("f3_00_illegal", 32'(r_ill), 32'd1);
        check("f3_00_we_pulses", 32'(r_we), 32'd0);
        check("f3_00_retire", 32'(r_ret), 32'd0);

        // CSRRS x9, mscratch, x0 with writeback stalled for 4 cycles
        do_op(F3_CSRRS, CSR_MSCRATCH, 32'd0, 5'd0, 5'd9, 4, 0);
        check("hold_lat", 32'(r_lat), 32'd3);
        check("hold_rsp_data", r_data, 32'hDEAD_BEEF);
        check("hold_rsp_retire", 32'(r_ret), 32'd1);

        // CSRRSI x4, mtvec, 0x10 with done on the last allowed cycle
        done_delay = 8;
        do_op(F3_CSRRSI, CSR_MTVEC, 32'd0, 5'h10, 5'd4, 0, 0);
        check("late_lat", 32'(r_lat), 32'd12);
        check("late_illegal", 32'(r_ill), 32'd0);
        check("late_wdata", last_wdata, 32'h110);
        check("late_data", r_data, 32'h100);
        check("late_rd_we", 32'(r_rdwe), 32'd1);
        check("late_retire", 32'(r_ret), 32'd1);

        // CSRRW x3, mscratch, x6 with write_done never arriving
        done_delay = 0;
        do_op(F3_CSRRW, CSR_MSCRATCH, 32'h1234, 5'd6, 5'd3, 0, 0);
        check("tmo_lat", 32'(r_lat), 32'd12);
        check("tmo_we_pulses", 32'(r_we), 32'd1);
        check("tmo_illegal", 32'(r_ill), 32'd1);
        check("tmo_rd_we", 32'(r_rdwe), 32'd0);
        check("tmo_retire", 32'(r_ret), 32'd0);
        check("tmo_data", r_data, 32'hDEAD_BEEF);

        // Reset while waiting for write_done
        do_op(F3_CSRRW, CSR_MEPC, 32'hAAAA, 5'd2, 5'd2, 0, 6);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_retire", 32'(bus.retire), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_csr_we", 32'(bus.csr_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);

        // CSRRS x1, cycle, x0: legal read of the cycle counter
        done_delay = 1;
        do_op(F3_CSRRS, CSR_CYCLE, 32'd0, 5'd0, 5'd1, 0, 0);
        check("cyc_lat", 32'(r_lat), 32'd3);
        check("cyc_illegal", 32'(r_ill), 32'd0);
        check("cyc_data", r_data, r_cyc_snap);
        check("cyc_rd_we", 32'(r_rdwe), 32'd1);
        check("cyc_retire", 32'(r_ret), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
